// File: rtl/aes_block_packer.sv
// aes_block_packer: packs a byte stream into PKCS#7-padded 128-bit blocks and issues them to the AES core
module aes_block_packer #(
    parameter int SIZE_DATA = 128,
    parameter int SIZE_KEY  = 256,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [7:0]           s_data_i,
    input  logic                 s_last_i,
    input  logic [SIZE_KEY-1:0]  key_i,
    input  logic [1:0]           type_i,
    output logic                 aes_ready_o,
    output logic [1:0]           aes_type_o,
    output logic [SIZE_DATA-1:0] plain_text_o,
    output logic [SIZE_KEY-1:0]  cipher_key_o,
    input  logic                 aes_done_i,
    output logic                 busy_o,
    output logic                 msg_done_o,
    output logic [CNT_W-1:0]     blk_cnt_o
);
    typedef enum logic [2:0] {IDLE, FILL, PAD, ISSUE, WAIT_DONE, PADFULL} state_e;
    state_e state_q, state_d;
    logic [3:0] idx_q, pad_n;
    logic full_pad_q, final_q, accept;
    assign accept = s_valid_i & s_ready_o;
    assign busy_o = state_q != IDLE;
    // idx_q holds k+1 after the last byte, so 16-idx_q is the pad value
    assign pad_n = 4'd0 - idx_q;
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (accept) state_d = s_last_i ? PAD : FILL;
            FILL:      if (accept) state_d = idx_q == 4'd15 ? ISSUE : s_last_i ? PAD : FILL;
            PAD:       state_d = ISSUE;
            PADFULL:   state_d = ISSUE;
            ISSUE:     state_d = WAIT_DONE;
            WAIT_DONE: if (aes_done_i) state_d = full_pad_q ? PADFULL : final_q ? IDLE : FILL;
            default:   state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            full_pad_q   <= 1'b0;
            final_q      <= 1'b0;
            s_ready_o    <= 1'b0;
            aes_ready_o  <= 1'b0;
            msg_done_o   <= 1'b0;
            plain_text_o <= '0;
            cipher_key_o <= '0;
            aes_type_o   <= 2'd0;
            blk_cnt_o    <= '0;
        end else begin
            state_q     <= state_d;
            s_ready_o   <= state_d == IDLE || state_d == FILL;
            aes_ready_o <= state_d == WAIT_DONE;
            msg_done_o  <= state_q == WAIT_DONE && aes_done_i && !full_pad_q && final_q;
            if (accept) begin
                for (int i = 0; i < 16; i++)
                    if (4'(i) == idx_q) plain_text_o[SIZE_DATA-1-8*i -: 8] <= s_data_i;
                idx_q <= idx_q + 4'd1;
                if (state_q == IDLE) begin
                    cipher_key_o <= key_i;
                    aes_type_o   <= type_i;
                    blk_cnt_o    <= '0;
                    full_pad_q   <= 1'b0;
                    final_q      <= 1'b0;
                end
                if (state_q == FILL && idx_q == 4'd15 && s_last_i) full_pad_q <= 1'b1;
            end
            if (state_q == PAD) begin
                for (int i = 0; i < 16; i++)
                    if (4'(i) >= idx_q) plain_text_o[SIZE_DATA-1-8*i -: 8] <= {4'd0, pad_n};
                final_q <= 1'b1;
            end
            if (state_q == PADFULL) begin
                plain_text_o <= {(SIZE_DATA/8){8'h10}};
                full_pad_q   <= 1'b0;
                final_q      <= 1'b1;
            end
            if (state_q == ISSUE) blk_cnt_o <= &blk_cnt_o ? blk_cnt_o : blk_cnt_o + 1'b1;
            if (state_q == WAIT_DONE && aes_done_i) idx_q <= 4'd0;
        end
    end
endmodule

// File: tb/tb_aes_block_packer.sv
// tb_aes_block_packer: directed tests for the AES block packer
module tb_aes_block_packer;
    logic         clk_i = 1'b0, rst_ni = 1'b0;
    logic         s_valid_i = 1'b0, s_ready_o, s_last_i = 1'b0;
    logic [7:0]   s_data_i = 8'h00;
    logic [255:0] key_i = '0;
    logic [1:0]   type_i = 2'd0;
    logic         aes_ready_o, aes_done_i = 1'b0, busy_o, msg_done_o;
    logic [1:0]   aes_type_o;
    logic [127:0] plain_text_o;
    logic [255:0] cipher_key_o;
    logic [15:0]  blk_cnt_o;
    int checks = 0, fails = 0;

    localparam logic [255:0] K1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K2 = {256{1'b1}};
    localparam logic [255:0] K3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_block_packer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .s_data_i(s_data_i), .s_last_i(s_last_i), .key_i(key_i), .type_i(type_i),
        .aes_ready_o(aes_ready_o), .aes_type_o(aes_type_o), .plain_text_o(plain_text_o),
        .cipher_key_o(cipher_key_o), .aes_done_i(aes_done_i), .busy_o(busy_o),
        .msg_done_o(msg_done_o), .blk_cnt_o(blk_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        s_valid_i = 1'b1; s_data_i = d; s_last_i = l;
        while (!s_ready_o && n < 100) begin tick(); n++; end
        if (!s_ready_o) begin checks++; fails++; $display("FAIL send_timeout: s_ready_o=%b required 1", s_ready_o); end
        tick();
        s_valid_i = 1'b0; s_last_i = 1'b0;
    endtask

    task automatic complete();
        aes_done_i = 1'b1;
        tick();
        aes_done_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({s_ready_o, aes_ready_o, msg_done_o, busy_o} !== 4'b0000) begin fails++; $display("FAIL reset_ctrl: got %b required 0000", {s_ready_o, aes_ready_o, msg_done_o, busy_o}); end
        checks++; if (plain_text_o !== '0 || cipher_key_o !== '0 || aes_type_o !== 2'd0 || blk_cnt_o !== 16'd0) begin fails++; $display("FAIL reset_data: pt=%h key=%h type=%0d cnt=%0d required all 0", plain_text_o, cipher_key_o, aes_type_o, blk_cnt_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        checks++; if (s_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", s_ready_o); end
    endtask

    task automatic test_short_msg();
        key_i = K1; type_i = 2'd0;
        send_byte(8'h61, 1'b0);
        checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL short_busy: got %b required 1", busy_o); end
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        aes_done_i = 1'b1;
        checks++; if (s_ready_o !== 1'b0 || aes_ready_o !== 1'b0) begin fails++; $display("FAIL short_pad_state: ready=%b aes_ready=%b required 0 0", s_ready_o, aes_ready_o); end
        tick();
        tick();
        aes_done_i = 1'b0;
        checks++; if (aes_ready_o !== 1'b1) begin fails++; $display("FAIL short_aes_ready: got %b required 1", aes_ready_o); end
        checks++; if (plain_text_o !== 128'h6162630d0d0d0d0d0d0d0d0d0d0d0d0d) begin fails++; $display("FAIL short_block: got %h required 6162630d0d0d0d0d0d0d0d0d0d0d0d0d", plain_text_o); end
        checks++; if (blk_cnt_o !== 16'd1 || cipher_key_o !== K1 || aes_type_o !== 2'd0) begin fails++; $display("FAIL short_meta: cnt=%0d key=%h type=%0d", blk_cnt_o, cipher_key_o, aes_type_o); end
        tick();
        tick();
        checks++; if (aes_ready_o !== 1'b1 || msg_done_o !== 1'b0) begin fails++; $display("FAIL short_hold: aes_ready=%b msg_done=%b required 1 0", aes_ready_o, msg_done_o); end
        complete();
        checks++; if ({aes_ready_o, msg_done_o, s_ready_o, busy_o} !== 4'b0110) begin fails++; $display("FAIL short_done: got %b required 0110", {aes_ready_o, msg_done_o, s_ready_o, busy_o}); end
        tick();
        checks++; if (msg_done_o !== 1'b0) begin fails++; $display("FAIL short_pulse: got %b required 0", msg_done_o); end
    endtask

    task automatic test_full_block();
        for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
        tick();
        checks++; if (aes_ready_o !== 1'b1 || plain_text_o !== 128'h000102030405060708090a0b0c0d0e0f) begin fails++; $display("FAIL full_blk1: rdy=%b got %h required 000102030405060708090a0b0c0d0e0f", aes_ready_o, plain_text_o); end
        checks++; if (blk_cnt_o !== 16'd1) begin fails++; $display("FAIL full_cnt1: got %0d required 1", blk_cnt_o); end
        complete();
        checks++; if ({aes_ready_o, msg_done_o, s_ready_o} !== 3'b000) begin fails++; $display("FAIL full_mid: got %b required 000", {aes_ready_o, msg_done_o, s_ready_o}); end
        tick();
        tick();
        checks++; if (aes_ready_o !== 1'b1 || plain_text_o !== {16{8'h10}}) begin fails++; $display("FAIL full_blk2: rdy=%b got %h required all 10", aes_ready_o, plain_text_o); end
        checks++; if (blk_cnt_o !== 16'd2) begin fails++; $display("FAIL full_cnt2: got %0d required 2", blk_cnt_o); end
        complete();
        checks++; if (msg_done_o !== 1'b1 || s_ready_o !== 1'b1) begin fails++; $display("FAIL full_done: msg_done=%b ready=%b required 1 1", msg_done_o, s_ready_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) send_byte(8'(32 + i), 1'b0);
        s_valid_i = 1'b1; s_data_i = 8'haa; s_last_i = 1'b1;
        checks++; if (s_ready_o !== 1'b0) begin fails++; $display("FAIL b2b_issue_ready: got %b required 0", s_ready_o); end
        tick();
        checks++; if (aes_ready_o !== 1'b1 || plain_text_o !== 128'h202122232425262728292a2b2c2d2e2f) begin fails++; $display("FAIL b2b_blk1: rdy=%b got %h", aes_ready_o, plain_text_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (s_ready_o !== 1'b0) begin fails++; $display("FAIL b2b_wait_ready: got %b required 0", s_ready_o); end
        end
        complete();
        checks++; if (plain_text_o !== 128'h202122232425262728292a2b2c2d2e2f || s_ready_o !== 1'b1 || aes_ready_o !== 1'b0) begin fails++; $display("FAIL b2b_after_done: pt=%h ready=%b aes_ready=%b", plain_text_o, s_ready_o, aes_ready_o); end
        tick();
        s_valid_i = 1'b0; s_last_i = 1'b0;
        checks++; if (s_ready_o !== 1'b0) begin fails++; $display("FAIL b2b_accepted: ready=%b required 0", s_ready_o); end
        tick();
        tick();
        checks++; if (aes_ready_o !== 1'b1 || plain_text_o !== {8'haa, {15{8'h0f}}} || blk_cnt_o !== 16'd2) begin fails++; $display("FAIL b2b_blk2: rdy=%b pt=%h cnt=%0d", aes_ready_o, plain_text_o, blk_cnt_o); end
        complete();
        checks++; if (msg_done_o !== 1'b1) begin fails++; $display("FAIL b2b_done: got %b required 1", msg_done_o); end
    endtask

    task automatic test_stall();
        int bad = 0;
        key_i = K1; type_i = 2'd2;
        send_byte(8'h80, 1'b0);
        key_i = K2; type_i = 2'd1;
        for (int i = 1; i < 16; i++) send_byte(8'(128 + i), 1'b0);
        tick();
        checks++; if (aes_ready_o !== 1'b1) begin fails++; $display("FAIL stall_aes_ready: got %b required 1", aes_ready_o); end
        for (int i = 0; i < 50; i++) begin
            if (plain_text_o !== 128'h808182838485868788898a8b8c8d8e8f || cipher_key_o !== K1 || aes_type_o !== 2'd2 || s_ready_o !== 1'b0 || aes_ready_o !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL stall_stable: %0d unstable cycles, required 0", bad); end
        complete();
        checks++; if ({s_ready_o, msg_done_o, aes_ready_o} !== 3'b100) begin fails++; $display("FAIL stall_done: got %b required 100", {s_ready_o, msg_done_o, aes_ready_o}); end
        send_byte(8'h55, 1'b1);
        tick();
        tick();
        checks++; if (plain_text_o !== {8'h55, {15{8'h0f}}} || cipher_key_o !== K1 || aes_type_o !== 2'd2 || blk_cnt_o !== 16'd2) begin fails++; $display("FAIL stall_blk2: pt=%h type=%0d cnt=%0d", plain_text_o, aes_type_o, blk_cnt_o); end
        complete();
        checks++; if (msg_done_o !== 1'b1) begin fails++; $display("FAIL stall_msg_done: got %b required 1", msg_done_o); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        while (!aes_ready_o && n < 20) begin tick(); n++; end
        checks++; if (aes_ready_o !== 1'b1) begin fails++; $display("FAIL rmid_wait: got %b required 1", aes_ready_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if ({s_ready_o, aes_ready_o, msg_done_o, busy_o} !== 4'b0000) begin fails++; $display("FAIL rmid_ctrl: got %b required 0000", {s_ready_o, aes_ready_o, msg_done_o, busy_o}); end
        checks++; if (plain_text_o !== '0 || cipher_key_o !== '0 || aes_type_o !== 2'd0 || blk_cnt_o !== 16'd0) begin fails++; $display("FAIL rmid_data: pt=%h type=%0d cnt=%0d required 0", plain_text_o, aes_type_o, blk_cnt_o); end
        #2;
        rst_ni = 1'b1;
        tick();
        key_i = K3; type_i = 2'd3;
        send_byte(8'h44, 1'b1);
        tick();
        tick();
        checks++; if (aes_ready_o !== 1'b1 || plain_text_o !== {8'h44, {15{8'h0f}}}) begin fails++; $display("FAIL rmid_blk: rdy=%b got %h required 44 then 0f x15", aes_ready_o, plain_text_o); end
        checks++; if (blk_cnt_o !== 16'd1 || cipher_key_o !== K3 || aes_type_o !== 2'd3) begin fails++; $display("FAIL rmid_meta: cnt=%0d type=%0d key=%h", blk_cnt_o, aes_type_o, cipher_key_o); end
        complete();
        checks++; if (msg_done_o !== 1'b1) begin fails++; $display("FAIL rmid_done: got %b required 1", msg_done_o); end
    endtask

    task automatic test_pad_edge();
        for (int i = 0; i < 15; i++) send_byte(8'(160 + i), i == 14);
        tick();
        tick();
        checks++; if (aes_ready_o !== 1'b1 || plain_text_o !== 128'ha0a1a2a3a4a5a6a7a8a9aaabacadae01) begin fails++; $display("FAIL pad15_blk: rdy=%b got %h required a0a1a2a3a4a5a6a7a8a9aaabacadae01", aes_ready_o, plain_text_o); end
        complete();
        checks++; if (msg_done_o !== 1'b1 || blk_cnt_o !== 16'd1) begin fails++; $display("FAIL pad15_done: msg_done=%b cnt=%0d required 1 1", msg_done_o, blk_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_short_msg();
        test_full_block();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_pad_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
